// File: rtl/z_pack_pkg.sv
// Shared constants, entry layout and helpers for the z-bit packer.
// Optional macro: Z_BIT_PACKER_PARITY_EN adds a stored parity bit per entry.
package z_pack_pkg;

    localparam int DEFAULT_WORD_W     = 8;
    localparam int DEFAULT_FIFO_DEPTH = 4;

    // Width needed to hold a bit count in the range 0..word_w inclusive.
    function automatic int len_width(input int word_w);
        return $clog2(word_w + 1);
    endfunction

    localparam int DEFAULT_LEN_W = $clog2(DEFAULT_WORD_W + 1);

    // Entry layout for the default configuration; parameterised builds
    // declare the same layout with their own widths.
    typedef struct packed {
        logic [DEFAULT_WORD_W-1:0] data;
        logic [DEFAULT_LEN_W-1:0]  len;
`ifdef Z_BIT_PACKER_PARITY_EN
        logic                      parity;
`endif
    } z_pack_entry_t;

endpackage

// File: rtl/z_pack_fifo.sv
// Small register-based FIFO parameterised on entry type and depth.
// Head entry is read straight from storage so it is visible the cycle
// after a push into an empty FIFO. A push while full is accepted only
// when a pop happens in the same cycle.
module z_pack_fifo #(
    parameter type entry_t = logic [7:0],
    parameter int  DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  entry_t                     push_data,
    input  logic                       pop,
    output entry_t                     pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               wr_en;
    logic               rd_en;

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == CNT_W'(DEPTH));
    assign rd_en    = pop && !empty;
    assign wr_en    = push && (!full || rd_en);
    assign pop_data = mem[rd_ptr_reg];
    assign count    = count_reg;

    // Storage: cleared on reset so the head reads as zero when empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally (depth is 2^n).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/z_bit_packer.sv
// Packs a qualified stream of z bits LSB-first into WORD_W-bit words,
// buffers them in a FIFO and presents them on a valid/ready interface.
// Partial words can be flushed; dropped words set a sticky overflow flag.
// Optional macro: Z_BIT_PACKER_PARITY_EN adds out_parity (XOR of out_data).
module z_bit_packer
    import z_pack_pkg::*;
#(
    parameter int WORD_W     = DEFAULT_WORD_W,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    input  logic                            in_bit,
    input  logic                            flush,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WORD_W-1:0]               out_data,
    output logic [$clog2(WORD_W+1)-1:0]     out_len,
`ifdef Z_BIT_PACKER_PARITY_EN
    output logic                            out_parity,
`endif
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fill_cnt,
    output logic                            overflow
);

    localparam int LEN_W  = len_width(WORD_W);
    localparam int CNT_W  = $clog2(WORD_W);
    localparam int FILL_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic [LEN_W-1:0]  len;
`ifdef Z_BIT_PACKER_PARITY_EN
        logic              parity;
`endif
    } entry_t;

    typedef enum logic {
        ST_IDLE,
        ST_FILL
    } pack_state_t;

    pack_state_t       state_reg;
    pack_state_t       state_next;
    logic [CNT_W-1:0]  bit_cnt_reg;
    logic [CNT_W-1:0]  bit_cnt_next;
    logic [WORD_W-1:0] shreg_reg;
    logic [WORD_W-1:0] shreg_next;
    logic              overflow_reg;

    logic [WORD_W-1:0] word_bits;
    logic [LEN_W-1:0]  word_len;
    logic              word_done;
    logic              push_req;
    entry_t            push_entry;
    entry_t            head_entry;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic [FILL_W-1:0] fifo_count;

    // Packing state register: state, bit counter and shift register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            bit_cnt_reg <= '0;
            shreg_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            shreg_reg   <= shreg_next;
        end
    end

    // Next-state logic: merge the incoming bit, decide whether a word is
    // pushed (full word or flush), and restart cleanly in the same cycle.
    always_comb begin
        word_bits    = (state_reg == ST_FILL) ? shreg_reg : '0;
        word_len     = LEN_W'(bit_cnt_reg);
        bit_cnt_next = bit_cnt_reg;
        shreg_next   = shreg_reg;
        state_next   = state_reg;

        if (in_valid) begin
            word_bits = word_bits | (WORD_W'(in_bit) << bit_cnt_reg);
            word_len  = word_len + LEN_W'(1);
        end

        word_done = in_valid && (bit_cnt_reg == CNT_W'(WORD_W - 1));
        push_req  = word_done || (flush && (word_len != '0));

        if (push_req) begin
            bit_cnt_next = '0;
            shreg_next   = '0;
        end else if (in_valid) begin
            bit_cnt_next = bit_cnt_reg + CNT_W'(1);
            shreg_next   = word_bits;
        end

        state_next = (bit_cnt_next == '0) ? ST_IDLE : ST_FILL;
    end

    // Entry assembled from the merged word; bits above len are already zero.
    always_comb begin
        push_entry      = '0;
        push_entry.data = word_bits;
        push_entry.len  = word_len;
`ifdef Z_BIT_PACKER_PARITY_EN
        push_entry.parity = ^word_bits;
`endif
    end

    assign pop = !fifo_empty && out_ready;

    z_pack_fifo #(
        .entry_t (entry_t),
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (reset),
        .push      (push_req),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Sticky overflow: set when a word is dropped, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_reg <= 1'b0;
        end else if (push_req && fifo_full && !pop) begin
            overflow_reg <= 1'b1;
        end
    end

    assign out_valid = !fifo_empty;
    assign out_data  = head_entry.data;
    assign out_len   = head_entry.len;
`ifdef Z_BIT_PACKER_PARITY_EN
    assign out_parity = head_entry.parity;
`endif
    assign fill_cnt  = fifo_count;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_z_bit_packer.sv
// Directed testbench for z_bit_packer (default WORD_W=8, FIFO_DEPTH=4).
// Covers packing, flush, overflow, full push+pop, and reset mid-word.
// Optional macro: Z_BIT_PACKER_PARITY_EN enables parity checks.
module tb_z_bit_packer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       flush = 1'b0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [7:0] out_data;
    logic [3:0] out_len;
    logic [2:0] fill_cnt;
    logic       overflow;
`ifdef Z_BIT_PACKER_PARITY_EN
    logic       out_parity;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    z_bit_packer #(
        .WORD_W     (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_bit     (in_bit),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_len    (out_len),
`ifdef Z_BIT_PACKER_PARITY_EN
        .out_parity (out_parity),
`endif
        .fill_cnt   (fill_cnt),
        .overflow   (overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Shift one full word in, LSB first, one bit per cycle.
    task automatic send_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_bit   = w[i];
            tick();
        end
        in_valid = 1'b0;
        in_bit   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", out_data); end
        checks++; if (out_len !== 4'd0) begin failures++; $display("FAIL reset_len got=%0d exp=0", out_len); end
        checks++; if (fill_cnt !== 3'd0) begin failures++; $display("FAIL reset_fill got=%0d exp=0", fill_cnt); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        reset = 1'b0;
        tick();
        $display("reset: released");
    endtask

    task automatic test_basic_word();
        out_ready = 1'b1;
        send_word(8'h4D);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 8'h4D) begin failures++; $display("FAIL basic_data got=%h exp=4d", out_data); end
        checks++; if (out_len !== 4'd8) begin failures++; $display("FAIL basic_len got=%0d exp=8", out_len); end
`ifdef Z_BIT_PACKER_PARITY_EN
        checks++; if (out_parity !== 1'b0) begin failures++; $display("FAIL basic_parity got=%b exp=0", out_parity); end
`endif
        $display("word: data=%h len=%0d", out_data, out_len);
        tick();
        checks++; if (fill_cnt !== 3'd0) begin failures++; $display("FAIL basic_fill_after_pop got=%0d exp=0", fill_cnt); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_after_pop got=%b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_bit = 1'b1; tick();
        end
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_no_early_word got=%b exp=0", out_valid); end
        flush = 1'b1; tick(); flush = 1'b0;
        checks++; if (out_data !== 8'h07) begin failures++; $display("FAIL flush_data got=%h exp=07", out_data); end
        checks++; if (out_len !== 4'd3) begin failures++; $display("FAIL flush_len got=%0d exp=3", out_len); end
`ifdef Z_BIT_PACKER_PARITY_EN
        checks++; if (out_parity !== 1'b1) begin failures++; $display("FAIL flush_parity got=%b exp=1", out_parity); end
`endif
        // Holding with out_ready low keeps the head stable.
        tick();
        checks++; if (out_data !== 8'h07 || out_len !== 4'd3) begin failures++; $display("FAIL flush_hold got=%h/%0d exp=07/3", out_data, out_len); end
        $display("word: data=%h len=%0d (flush)", out_data, out_len);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        // A lone flush with nothing collected is a no-op.
        flush = 1'b1; tick(); flush = 1'b0;
        checks++; if (fill_cnt !== 3'd0) begin failures++; $display("FAIL flush_noop_fill got=%0d exp=0", fill_cnt); end
        // Flush with in_valid at bit_cnt 0 -> 1-bit word.
        flush = 1'b1; in_valid = 1'b1; in_bit = 1'b1; tick();
        flush = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
        checks++; if (out_data !== 8'h01 || out_len !== 4'd1) begin failures++; $display("FAIL flush_1bit got=%h/%0d exp=01/1", out_data, out_len); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        // Two bits then bit+flush -> the flushing bit is included: 1,0,1 = 05 len 3.
        in_valid = 1'b1; in_bit = 1'b1; tick();
        in_bit = 1'b0; tick();
        in_bit = 1'b1; flush = 1'b1; tick();
        in_valid = 1'b0; flush = 1'b0; in_bit = 1'b0;
        checks++; if (out_data !== 8'h05 || out_len !== 4'd3) begin failures++; $display("FAIL flush_with_bit got=%h/%0d exp=05/3", out_data, out_len); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        // Flush on the completing bit yields exactly one full word (8'h81).
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_bit   = (i == 0 || i == 7);
            flush    = (i == 7);
            tick();
        end
        in_valid = 1'b0; in_bit = 1'b0; flush = 1'b0;
        tick();
        checks++; if (fill_cnt !== 3'd1) begin failures++; $display("FAIL flush_complete_count got=%0d exp=1", fill_cnt); end
        checks++; if (out_data !== 8'h81 || out_len !== 4'd8) begin failures++; $display("FAIL flush_complete_word got=%h/%0d exp=81/8", out_data, out_len); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        for (int w = 0; w < 4; w++) begin
            send_word(8'hFF);
        end
        checks++; if (fill_cnt !== 3'd4 || overflow !== 1'b0) begin failures++; $display("FAIL ovf_four got=%0d/%b exp=4/0", fill_cnt, overflow); end
        send_word(8'hFF);
        checks++; if (fill_cnt !== 3'd4) begin failures++; $display("FAIL ovf_fill got=%0d exp=4", fill_cnt); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== 8'hFF) begin failures++; $display("FAIL ovf_drain%0d got=%b/%h exp=1/ff", i, out_valid, out_data); end
            $display("drain: data=%h len=%0d", out_data, out_len);
            tick();
        end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ovf_drain_end got=%b exp=0", out_valid); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
        out_ready = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0;
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_reset_clear got=%b exp=0", overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] pat;
        logic [7:0] exp_q [4];
        exp_q[0] = 8'h02; exp_q[1] = 8'h03; exp_q[2] = 8'h04; exp_q[3] = 8'hA5;
        out_ready = 1'b0;
        send_word(8'h01); send_word(8'h02); send_word(8'h03); send_word(8'h04);
        pat = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            in_valid  = 1'b1;
            in_bit    = pat[i];
            out_ready = (i == 7);
            tick();
        end
        in_valid = 1'b0; in_bit = 1'b0;
        checks++; if (fill_cnt !== 3'd4) begin failures++; $display("FAIL fullpp_fill got=%0d exp=4", fill_cnt); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fullpp_ovf got=%b exp=0", overflow); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== exp_q[i]) begin failures++; $display("FAIL fullpp_order%0d got=%b/%h exp=1/%h", i, out_valid, out_data, exp_q[i]); end
            $display("drain: data=%h len=%0d", out_data, out_len);
            tick();
        end
        checks++; if (out_valid !== 1'b0 || fill_cnt !== 3'd0) begin failures++; $display("FAIL fullpp_empty got=%b/%0d exp=0/0", out_valid, fill_cnt); end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_word();
        logic [4:0] pat;
        pat = 5'b10101;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_bit = pat[i]; tick();
        end
        in_valid = 1'b0; in_bit = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0;
        checks++; if (out_valid !== 1'b0 || fill_cnt !== 3'd0) begin failures++; $display("FAIL midrst_empty got=%b/%0d exp=0/0", out_valid, fill_cnt); end
        send_word(8'hFF);
        checks++; if (fill_cnt !== 3'd1) begin failures++; $display("FAIL midrst_fill got=%0d exp=1", fill_cnt); end
        checks++; if (out_data !== 8'hFF || out_len !== 4'd8) begin failures++; $display("FAIL midrst_word got=%h/%0d exp=ff/8", out_data, out_len); end
        $display("word: data=%h len=%0d (after reset)", out_data, out_len);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0 || fill_cnt !== 3'd0) begin failures++; $display("FAIL midrst_no_partial got=%b/%0d exp=0/0", out_valid, fill_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic_word();
        test_flush();
        test_overflow();
        test_full_push_pop();
        test_reset_mid_word();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/z_bit_packer.md
Name: z_bit_packer

Overview:
- Downstream consumer of the single-bit z output produced by the x/y boolean stage.
- Collects a qualified stream of z bits LSB-first into WORD_W-bit words.
- Buffers completed words in a small FIFO and presents them on a valid/ready interface for logging or scoreboarding.
- Supports flushing a partial word, and keeps a sticky overflow flag for words dropped when the FIFO is full.

Parameters:
- WORD_W, 8, bits per packed word (≥2).
- FIFO_DEPTH, 4, number of word entries in the output FIFO (power of two, ≥2).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous reset, active-high.
- in_valid  in  1  in_bit is sampled this cycle.
- in_bit  in  1  z bit from the upstream boolean stage.
- flush  in  1  emit the current partial word, zero-padded.
- out_valid  out  1  FIFO head word is valid.
- out_ready  in  1  consumer accepts the head word.
- out_data  out  WORD_W  packed word; first-received bit is bit 0.
- out_len  out  $clog2(WORD_W+1)  number of real bits in out_data (1..WORD_W).
- fill_cnt  out  $clog2(FIFO_DEPTH+1)  number of occupied FIFO entries.
- overflow  out  1  sticky flag: a word was dropped.

Behaviour:
- Reset (async assert, released synchronously to clk):
  - out_valid=0, out_data=0, out_len=0, fill_cnt=0, overflow=0.
  - bit_cnt=0, shift register cleared, FIFO empty.
  - Reset mid-word discards the partial word; no emission.
- Packing state:
  - IDLE when bit_cnt==0; FILL when 0<bit_cnt<WORD_W.
  - On in_valid: shreg[bit_cnt]<=in_bit and bit_cnt increments.
  - in_valid with bit_cnt==WORD_W-1 completes the word:
    - push {shreg | in_bit<<(WORD_W-1), len=WORD_W};
    - bit_cnt->0 and shreg cleared in the same cycle (back-to-back words need no bubble).
- Flush:
  - flush with bit_cnt>0 pushes the partial word, zero-padded above len.
  - len = bit_cnt, or bit_cnt+1 if in_valid is also high (the bit is included).
  - flush coincident with word completion produces exactly one word, len=WORD_W.
  - flush with bit_cnt==0 and no in_valid is a no-op.
  - flush with bit_cnt==0 and in_valid pushes a 1-bit word.
  - After a push, bit_cnt->0.
- Latency:
  - A pushed word appears at the FIFO head with out_valid=1 on the next cycle, if the FIFO was empty.
  - The FIFO is registered; there is no combinational path from in_* to out_*.
- Output handshake:
  - out_valid = FIFO non-empty.
  - Pop when out_valid && out_ready.
  - out_data/out_len are held stable while out_valid && !out_ready.
  - Words leave in push order.
- Full FIFO:
  - Push with fill_cnt==FIFO_DEPTH and no pop in the same cycle: word dropped, overflow<=1.
  - overflow clears only on reset.
  - Push and pop in the same cycle while full: push accepted, fill_cnt unchanged, no overflow.
- Empty FIFO: pop is impossible (out_valid=0); out_ready is ignored.
- fill_cnt: +1 on accepted push, −1 on pop, unchanged when both occur.

Optional Feature:
- Macro Z_BIT_PACKER_PARITY_EN.
- Defined:
  - adds output port out_parity (1 bit) = XOR of out_data, computed at push and stored per entry;
  - reset value 0; stable under the same rules as out_data.
- Undefined: port and storage are absent; all other behaviour is identical.

Decomposition:
- Package z_pack_pkg holds:
  - the default WORD_W/FIFO_DEPTH constants;
  - the entry struct typedef {data, len, parity (parity only under the macro)};
  - a function computing len width.
- One sub-module, z_pack_fifo:
  - synchronous FIFO parameterised on entry type and depth;
  - push/pop/full/empty/count interface;
  - async active-high reset.

Test Plan:
- Bits 1,0,1,1,0,0,1,0 on consecutive cycles, out_ready=1 -> one cycle after the 8th bit: out_valid=1, out_data=8'h4D, out_len=8, fill_cnt returns to 0 after the pop.
- Bits 1,1,1 then flush -> out_data=8'h07, out_len=3. A second flush alone -> no new word.
- out_ready=0, five full words of 8'hFF -> fill_cnt=4, overflow=1 after the 5th. Then out_ready=1 -> exactly four 8'hFF words drain, overflow stays 1.
- FIFO full (4 words), out_ready=1 on the cycle a 5th word (8'hA5) completes -> no overflow, fill_cnt stays 4, 8'hA5 is the last word drained.
- Five bits 1,0,1,0,1, then reset pulse, then eight bits all 1 -> single word 8'hFF, len=8; no partial word emitted.
- With Z_BIT_PACKER_PARITY_EN: word 8'h4D -> out_parity=0; word 8'h07 (len 3) -> out_parity=1.
